// File: rtl/max_tree_stream.sv
// Streaming max-search engine: a registered comparison tree finds each beat's max and an
// accumulator keeps the running max of a packet, reporting value, {beat,lane} position and flags.
module max_tree_stream #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEAT_W = 16,
  localparam int unsigned STAGES = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W-1:0]   s_data,
  input  logic [LANES-1:0]          s_keep,
  input  logic                      s_first,
  input  logic                      s_last,
  input  logic                      signed_mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_max,
  output logic [BEAT_W+STAGES-1:0]  m_index,
  output logic                      m_empty,
  output logic                      m_ovf
);

  localparam int unsigned IdxW = BEAT_W + STAGES;
  localparam logic [BEAT_W-1:0] BeatMax = '1;

  // True when entry b must replace entry a; a holds the lower position, so ties keep a.
  function automatic logic b_wins(input logic va, input logic vb,
                                  input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                                  input logic sm);
    logic gt;
    gt = sm ? ($signed(db) > $signed(da)) : (db > da);
    return vb && (!va || gt);
  endfunction

  logic adv;
  logic accept;
  logic m_valid_q, m_valid_d;

  assign adv     = !(m_valid_q && !m_ready);
  assign s_ready = adv;
  assign accept  = s_valid && adv;
  assign m_valid = m_valid_q;

  // Input packet tracking: open flag, beat counter, latched mode and overflow.
  logic              open_q, open_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              ovf_q, ovf_d;
  logic              in_pv;

  always_comb begin
    open_d = open_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    in_pv  = 1'b0;
    if (accept) begin
      if (s_first) begin
        in_pv  = 1'b1;
        open_d = !s_last;
        cnt_d  = '0;
        mode_d = signed_mode;
        ovf_d  = 1'b0;
      end else if (open_q) begin
        in_pv  = 1'b1;
        open_d = !s_last;
        if (cnt_q == BeatMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  // Per-beat sideband travelling alongside the tree, one slot per level.
  logic [STAGES:0]             pv_q;
  logic [STAGES:0]             first_q;
  logic [STAGES:0]             last_q;
  logic [STAGES:0]             smode_q;
  logic [STAGES:0]             povf_q;
  logic [STAGES:0][BEAT_W-1:0] beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= '0;
      first_q <= '0;
      last_q  <= '0;
      smode_q <= '0;
      povf_q  <= '0;
      beat_q  <= '0;
    end else if (adv) begin
      pv_q    <= {pv_q[STAGES-1:0], in_pv};
      first_q <= {first_q[STAGES-1:0], s_first};
      last_q  <= {last_q[STAGES-1:0], s_last};
      smode_q <= {smode_q[STAGES-1:0], mode_d};
      povf_q  <= {povf_q[STAGES-1:0], ovf_d};
      beat_q  <= {beat_q[STAGES-1:0], cnt_d};
    end
  end

  for (genvar k = 0; k <= STAGES; k++) begin : g_lvl
    localparam int unsigned N = LANES >> k;
    logic [N-1:0]              v_q;
    logic [N-1:0][DATA_W-1:0]  d_q;
    logic [N-1:0][STAGES-1:0]  i_q;

    if (k == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_idx
        assign i_q[j] = STAGES'(j);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          d_q <= '0;
        end else if (adv) begin
          v_q <= s_keep;
          d_q <= s_data;
        end
      end
    end else begin : g_cmp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          d_q <= '0;
          i_q <= '0;
        end else if (adv) begin
          for (int j = 0; j < int'(N); j++) begin
            v_q[j] <= g_lvl[k-1].v_q[2*j] | g_lvl[k-1].v_q[2*j+1];
            if (b_wins(g_lvl[k-1].v_q[2*j], g_lvl[k-1].v_q[2*j+1],
                       g_lvl[k-1].d_q[2*j], g_lvl[k-1].d_q[2*j+1], smode_q[k-1])) begin
              d_q[j] <= g_lvl[k-1].d_q[2*j+1];
              i_q[j] <= g_lvl[k-1].i_q[2*j+1];
            end else begin
              d_q[j] <= g_lvl[k-1].d_q[2*j];
              i_q[j] <= g_lvl[k-1].i_q[2*j];
            end
          end
        end
      end
    end
  end

  logic              top_v;
  logic [DATA_W-1:0] top_d;
  logic [STAGES-1:0] top_i;

  assign top_v = g_lvl[STAGES].v_q[0];
  assign top_d = g_lvl[STAGES].d_q[0];
  assign top_i = g_lvl[STAGES].i_q[0];

  logic              acc_v_q, acc_v_d;
  logic [DATA_W-1:0] acc_d_q, acc_d_d;
  logic [IdxW-1:0]   acc_i_q, acc_i_d;
  logic              acc_en;
  logic              load;

  assign acc_en = adv && pv_q[STAGES];
  assign load   = acc_en && last_q[STAGES];

  // A first beat always restarts the accumulator, even when none of its lanes are kept.
  always_comb begin
    acc_v_d = acc_v_q;
    acc_d_d = acc_d_q;
    acc_i_d = acc_i_q;
    if (first_q[STAGES] || b_wins(acc_v_q, top_v, acc_d_q, top_d, smode_q[STAGES])) begin
      acc_v_d = top_v;
      acc_d_d = top_d;
      acc_i_d = {beat_q[STAGES], top_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v_q <= 1'b0;
      acc_d_q <= '0;
      acc_i_q <= '0;
    end else if (acc_en) begin
      acc_v_q <= acc_v_d;
      acc_d_q <= acc_d_d;
      acc_i_q <= acc_i_d;
    end
  end

  logic [DATA_W-1:0] m_max_q, m_max_d;
  logic [IdxW-1:0]   m_index_q, m_index_d;
  logic              m_empty_q, m_empty_d;
  logic              m_ovf_q, m_ovf_d;

  always_comb begin
    m_valid_d = m_valid_q && !m_ready;
    m_max_d   = m_max_q;
    m_index_d = m_index_q;
    m_empty_d = m_empty_q;
    m_ovf_d   = m_ovf_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_max_d   = acc_v_d ? acc_d_d : '0;
      m_index_d = acc_v_d ? acc_i_d : '0;
      m_empty_d = !acc_v_d;
      m_ovf_d   = povf_q[STAGES];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_max_q   <= '0;
      m_index_q <= '0;
      m_empty_q <= 1'b0;
      m_ovf_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_max_q   <= m_max_d;
      m_index_q <= m_index_d;
      m_empty_q <= m_empty_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_max   = m_max_q;
  assign m_index = m_index_q;
  assign m_empty = m_empty_q;
  assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_max_tree_stream.sv
// Bench for max_tree_stream: two instances (BEAT_W=16 and BEAT_W=2) share one stimulus stream
// and are checked against a packet-level reference model plus literal expectations.
module tb_max_tree_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_first, s_last, signed_mode, m_ready;
  logic [255:0] s_data;
  logic [7:0]   s_keep;
  logic         s_ready, m_valid, m_empty, m_ovf;
  logic [31:0]  m_max;
  logic [18:0]  m_index;
  logic         s_ready2, m_valid2, m_empty2, m_ovf2;
  logic [31:0]  m_max2;
  logic [4:0]   m_index2;

  max_tree_stream #(.LANES(8), .DATA_W(32), .BEAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_keep(s_keep), .s_first(s_first), .s_last(s_last), .signed_mode(signed_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_max(m_max), .m_index(m_index),
    .m_empty(m_empty), .m_ovf(m_ovf)
  );

  max_tree_stream #(.LANES(8), .DATA_W(32), .BEAT_W(2)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_keep(s_keep), .s_first(s_first), .s_last(s_last), .signed_mode(signed_mode),
    .m_valid(m_valid2), .m_ready(m_ready), .m_max(m_max2), .m_index(m_index2),
    .m_empty(m_empty2), .m_ovf(m_ovf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mx;
    int          idx;
    logic        em;
    logic        ov;
  } res_t;

  int           total = 0;
  int           bad = 0;
  res_t         q16[$];
  res_t         q2[$];
  logic [255:0] pd[$];
  logic [7:0]   pk[$];
  logic         open_m = 1'b0;
  logic         mode_m = 1'b0;
  logic         hv[2];
  res_t         hold[2];
  logic         saw_stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Flat scan of the whole packet in arrival order; strict '>' keeps the earliest position.
  function automatic res_t model_pkt(input int bw);
    res_t        r;
    int          maxb;
    int          bn;
    logic [31:0] v;
    logic        have;
    maxb = (1 << bw) - 1;
    have = 1'b0;
    r.mx = '0;
    r.idx = 0;
    r.ov = (pd.size() - 1) > maxb;
    for (int b = 0; b < pd.size(); b++) begin
      bn = (b > maxb) ? maxb : b;
      for (int l = 0; l < 8; l++) begin
        if (pk[b][l]) begin
          v = pd[b][l*32 +: 32];
          if (!have || (mode_m ? ($signed(v) > $signed(r.mx)) : (v > r.mx))) begin
            have = 1'b1;
            r.mx = v;
            r.idx = bn * 8 + l;
          end
        end
      end
    end
    r.em = !have;
    return r;
  endfunction

  task automatic model_beat();
    if (s_first) begin
      open_m = 1'b1;
      mode_m = signed_mode;
      pd.delete();
      pk.delete();
    end else if (!open_m) begin
      return;
    end
    pd.push_back(s_data);
    pk.push_back(s_keep);
    if (s_last) begin
      q16.push_back(model_pkt(16));
      q2.push_back(model_pkt(2));
      open_m = 1'b0;
    end
  endtask

  task automatic check_dut(input int w, input logic v, input logic [31:0] mx, input int idx,
                           input logic em, input logic ov);
    res_t e;
    logic empty_q;
    if (hv[w]) begin
      chk($sformatf("hold_valid%0d", w), 64'(v), 64'(1));
      chk($sformatf("hold_max%0d", w), 64'(mx), 64'(hold[w].mx));
      chk($sformatf("hold_idx%0d", w), 64'(idx), 64'(hold[w].idx));
      chk($sformatf("hold_flags%0d", w), 64'({em, ov}), 64'({hold[w].em, hold[w].ov}));
    end
    if (v && m_ready) begin
      empty_q = (w == 0) ? (q16.size() == 0) : (q2.size() == 0);
      if (empty_q) begin
        total++;
        bad++;
        $display("FAIL spurious_result%0d: got result max=%0h, expected no result", w, mx);
      end else begin
        if (w == 0) e = q16.pop_front();
        else e = q2.pop_front();
        chk($sformatf("model_max%0d", w), 64'(mx), 64'(e.mx));
        chk($sformatf("model_idx%0d", w), 64'(idx), 64'(e.idx));
        chk($sformatf("model_empty%0d", w), 64'(em), 64'(e.em));
        chk($sformatf("model_ovf%0d", w), 64'(ov), 64'(e.ov));
      end
    end
    hv[w] = v && !m_ready;
    hold[w] = '{mx, idx, em, ov};
  endtask

  // Compare process: sample away from the rising edge; a handshake seen here completes at the
  // following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      open_m = 1'b0;
      pd.delete();
      pk.delete();
      q16.delete();
      q2.delete();
      hv[0] = 1'b0;
      hv[1] = 1'b0;
    end else begin
      check_dut(0, m_valid, m_max, int'(m_index), m_empty, m_ovf);
      check_dut(1, m_valid2, m_max2, int'(m_index2), m_empty2, m_ovf2);
      if (!s_ready) saw_stall = 1'b1;
      if (s_valid && s_ready) model_beat();
    end
  end

  function automatic logic [255:0] mk8(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [255:0] fill(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic send(input logic [255:0] d, input logic [7:0] k, input logic f, input logic l,
                      input logic sm);
    int n = 0;
    s_data = d;
    s_keep = k;
    s_first = f;
    s_last = l;
    signed_mode = sm;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Called right after the last beat's accepting edge; counts edges until m_valid.
  task automatic expect_res(input string nm, input logic [31:0] mx, input int i16, input int i2,
                            input logic em, input logic ov2);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!m_valid && n < 20);
    if (!m_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: m_valid=0 after %0d cycles, expected 1", nm, n);
    end else begin
      chk({nm, "_latency"}, 64'(n), 64'(4));
      chk({nm, "_max"}, 64'(m_max), 64'(mx));
      chk({nm, "_idx"}, 64'(m_index), 64'(i16));
      chk({nm, "_empty"}, 64'(m_empty), 64'(em));
      chk({nm, "_ovf"}, 64'(m_ovf), 64'(0));
      chk({nm, "_max2"}, 64'(m_max2), 64'(mx));
      chk({nm, "_idx2"}, 64'(m_index2), 64'(i2));
      chk({nm, "_ovf2"}, 64'(m_ovf2), 64'(ov2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [255:0] d;
    int n;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; signed_mode = 1'b0;
    s_data = '0; s_keep = '0; m_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_max", 64'(m_max), 64'(0));
    chk("rst_m_index", 64'(m_index), 64'(0));
    chk("rst_flags", 64'({m_empty, m_ovf}), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_s_ready", 64'(s_ready), 64'(1));

    // Single beat, lane tie at 9 resolved to lower lane.
    send(mk8(1, 9, 3, 9, 0, 2, 7, 5), 8'hFF, 1, 1, 0);
    expect_res("t1", 32'd9, 1, 1, 0, 0);

    // Signed versus unsigned compare on the same data.
    d = mk8(32'hFFFF_FFFF, 32'h8000_0000, 2, 0, 0, 0, 0, 0);
    send(d, 8'hFF, 1, 1, 1);
    expect_res("t2_signed", 32'd2, 2, 2, 0, 0);
    send(d, 8'hFF, 1, 1, 0);
    expect_res("t2_unsigned", 32'hFFFF_FFFF, 0, 0, 0, 0);

    // Three beats, masked beat holds the largest raw value.
    send(fill(32'h10), 8'hFF, 1, 0, 0);
    send(fill(32'hFFFF), 8'h00, 0, 0, 0);
    send(mk8(32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h55, 32'h20), 8'hFF, 0, 1, 0);
    expect_res("t3_mask", 32'h55, 22, 22, 0, 0);
    send(fill(32'h77), 8'h00, 1, 1, 0);
    expect_res("t3_empty", 32'h0, 0, 0, 1, 0);
    // Equal maxima on different beats: earlier beat wins.
    send(mk8(1, 1, 1, 32'h70, 1, 1, 1, 1), 8'hFF, 1, 0, 0);
    send(mk8(32'h70, 1, 1, 1, 1, 1, 1, 1), 8'hFF, 0, 1, 0);
    expect_res("t3_tie", 32'h70, 3, 3, 0, 0);

    // Backpressure: stream packets while m_ready is held low for 10 cycles.
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          for (int l = 0; l < 8; l++) begin
            v = 32'((p * 37 + l * 11) % 50) - 32'd25;
            d[l*32 +: 32] = v;
          end
          if (p == 3) begin
            send(d, 8'hF0, 1, 0, 1);
            send(~d, 8'h0F, 0, 1, 1);
          end else begin
            send(d, (p == 5) ? 8'h00 : (8'hFF ^ (8'h01 << p)), 1, 1, p[0]);
          end
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("t4_stall_seen", 64'(saw_stall), 64'(1));
    chk("t4_drained16", 64'(q16.size()), 64'(0));
    chk("t4_drained2", 64'(q2.size()), 64'(0));

    // Reset with a result pending and a packet open.
    m_ready = 1'b0;
    send(mk8(32'h123, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1, 1, 0);
    send(fill(32'hAAAA), 8'hFF, 1, 0, 0);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t5_pending", 64'(m_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(m_valid), 64'(0));
    chk("t5_rst_valid2", 64'(m_valid2), 64'(0));
    m_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(fill(32'hFFFF), 8'hFF, 0, 1, 0);
    send(mk8(1, 2, 3, 4, 5, 32'h44, 6, 7), 8'hFF, 1, 1, 0);
    expect_res("t5_after", 32'h44, 5, 5, 0, 0);

    // Restart mid-packet drops the open packet.
    send(fill(32'h999), 8'hFF, 1, 0, 0);
    send(fill(32'h5), 8'hFF, 1, 0, 0);
    send(mk8(0, 0, 0, 0, 7, 0, 0, 0), 8'hFF, 0, 1, 0);
    expect_res("t6_restart", 32'h7, 12, 12, 0, 0);
    // Six beats overflow the 2-bit counter; four beats just fit.
    for (int b = 0; b < 6; b++) begin
      d = fill(32'(b));
      if (b == 5) d[2*32 +: 32] = 32'h100;
      send(d, 8'hFF, b == 0, b == 5, 0);
    end
    expect_res("t6_ovf", 32'h100, 42, 26, 0, 1);
    for (int b = 0; b < 4; b++) begin
      d = fill(32'h10);
      if (b == 3) d[31:0] = 32'h30;
      send(d, 8'hFF, b == 0, b == 3, 0);
    end
    expect_res("t6_fit", 32'h30, 24, 24, 0, 0);

    repeat (8) @(posedge clk);
    #1;
    chk("end_drained16", 64'(q16.size()), 64'(0));
    chk("end_drained2", 64'(q2.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
